// File: rtl/grid_frame_buffer.sv
// grid_frame_buffer
// Frame store for the grid drawer: accepts (x, y, colour) pixel writes, clears
// itself to the background colour after reset or on request, and scans the
// store out in raster order, one slot per pix_en strobe, with blanking slots.
module grid_frame_buffer #(
    parameter int         WIDTH     = 128,
    parameter int         HEIGHT    = 96,
    parameter int         H_BLANK   = 32,
    parameter int         V_BLANK   = 24,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       plot,
    input  logic [6:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic       plot_ready,
    input  logic       clear,
    output logic       busy,
    output logic [7:0] drop_count,
    input  logic       pix_en,
    output logic       pix_valid,
    output logic [2:0] pix_colour,
    output logic [6:0] pix_x,
    output logic [6:0] pix_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int DEPTH   = WIDTH * HEIGHT;
    localparam int AW      = $clog2(DEPTH);
    localparam int H_TOTAL = WIDTH + H_BLANK;
    localparam int V_TOTAL = HEIGHT + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS     = HW'(WIDTH);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS     = VW'(HEIGHT);
    localparam logic [7:0]    X_LIM     = 8'(WIDTH);
    localparam logic [7:0]    Y_LIM     = 8'(HEIGHT);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          pix_valid_q, pix_valid_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          vis_hold_q, vis_hold_d;
    logic [6:0]    pix_x_q, pix_x_d;
    logic [6:0]    pix_y_q, pix_y_d;

    // Store and its registered read word (RAM output register, no reset).
    logic [2:0]    mem [DEPTH];
    logic [2:0]    rd_word_q;

    logic          in_range;
    logic          visible;
    logic [AW-1:0] plot_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          drop;

    assign in_range  = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign plot_addr = AW'(y) * AW'(WIDTH) + AW'(x);
    assign visible   = (h_q < H_VIS) && (v_q < V_VIS);
    assign rd_addr   = visible ? (AW'(v_q) * AW'(WIDTH) + AW'(h_q)) : '0;

    // Write handshake: a write is taken on a clock edge where plot and
    // plot_ready are both high and (x, y) lies inside the store. plot_ready
    // is low for the whole clear; any plot not taken is counted as a drop and
    // never retried -- the drawer does not wait on plot_ready.

    // Clear/idle FSM, write-port mux and drop counter.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        drop_count_d = drop_count_q;
        wr_en        = 1'b0;
        wr_addr      = clr_addr_q;
        wr_data      = BG_COLOUR;
        busy         = 1'b0;
        plot_ready   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (clear) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    clr_addr_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                plot_ready = 1'b1;
                if (plot && in_range) begin
                    wr_en   = 1'b1;
                    wr_addr = plot_addr;
                    wr_data = colour;
                end
                // A plot in this same cycle still lands; the clear overwrites it.
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        drop = plot && !(plot_ready && in_range);
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Raster counters and scan-out output registers, advanced only on pix_en.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        pix_valid_d   = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        vis_hold_d    = vis_hold_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        if (pix_en) begin
            pix_valid_d   = visible;
            line_start_d  = (h_q == '0) && (v_q < V_VIS);
            frame_start_d = (h_q == '0) && (v_q == '0);
            vis_hold_d    = visible;
            pix_x_d       = h_q[6:0];
            pix_y_d       = v_q[6:0];
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= '0;
            drop_count_q  <= '0;
            h_q           <= '0;
            v_q           <= '0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vis_hold_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            drop_count_q  <= drop_count_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pix_valid_q   <= pix_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vis_hold_q    <= vis_hold_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
        end
    end

    // Single-clock store: one write port, one registered read port; a read of
    // the address being written in the same cycle returns the old word.
    always_ff @(posedge clock) begin
        if (wr_en && reset_n) begin
            mem[wr_addr] <= wr_data;
        end
        if (pix_en) begin
            rd_word_q <= mem[rd_addr];
        end
    end

    assign drop_count  = drop_count_q;
    assign pix_valid   = pix_valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_colour  = vis_hold_q ? rd_word_q : 3'b000;

endmodule

// File: tb/tb_grid_frame_buffer.sv
// Bench for grid_frame_buffer: a reference model of store, clear FSM, drop
// counter and raster counters predicts every cycle's outputs into a queue;
// each cycle the prediction is popped and compared with the DUT.
module tb_grid_frame_buffer;

    localparam int W     = 128;
    localparam int H     = 96;
    localparam int HT    = 160;
    localparam int VT    = 120;
    localparam int DEPTH = W * H;
    localparam int SB_W  = 31;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       plot = 1'b0;
    logic [6:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       clear = 1'b0;
    logic       pix_en = 1'b0;
    logic       plot_ready;
    logic       busy;
    logic [7:0] drop_count;
    logic       pix_valid;
    logic [2:0] pix_colour;
    logic [6:0] pix_x;
    logic [6:0] pix_y;
    logic       line_start;
    logic       frame_start;

    // Clock and DUT.
    always #5 clock = ~clock;

    grid_frame_buffer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot_ready  (plot_ready),
        .clear       (clear),
        .busy        (busy),
        .drop_count  (drop_count),
        .pix_en      (pix_en),
        .pix_valid   (pix_valid),
        .pix_colour  (pix_colour),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state.
    bit         m_busy;
    int         m_addr;
    int         m_drop;
    int         m_h;
    int         m_v;
    logic [2:0] m_mem [DEPTH];
    logic [2:0] last_col;
    logic [6:0] last_x;
    logic [6:0] last_y;
    logic       last_xcare;
    logic [SB_W-1:0] exp_q[$];

    int phase = 0;
    int n_valid, n_ls, n_fs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drop_inc();
        if (m_drop < 255) m_drop++;
    endtask

    // One clock: drive inputs, predict outcome, advance, compare.
    task automatic step(input logic p, input int px, input int py, input logic [2:0] pc,
                        input logic clr, input logic pen);
        logic            vis;
        logic            ev, els, efs;
        logic [SB_W-1:0] e, got;
        plot = p; x = 7'(px); y = 7'(py); colour = pc; clear = clr; pix_en = pen;
        ev = 1'b0; els = 1'b0; efs = 1'b0;
        if (pen) begin
            vis        = (m_h < W) && (m_v < H);
            last_col   = vis ? m_mem[m_v * W + m_h] : 3'b000;
            ev         = vis;
            els        = (m_h == 0) && (m_v < H);
            efs        = (m_h == 0) && (m_v == 0);
            last_x     = 7'(m_h);
            last_y     = 7'(m_v);
            last_xcare = vis;
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
        end
        if (m_busy) begin
            m_mem[m_addr] = 3'b000;
            if (p) drop_inc();
            if (clr) m_addr = 0;
            else if (m_addr == DEPTH - 1) begin m_busy = 0; m_addr = 0; end
            else m_addr++;
        end else begin
            if (p) begin
                if (px < W && py < H) m_mem[py * W + px] = pc;
                else drop_inc();
            end
            if (clr) begin m_busy = 1; m_addr = 0; end
        end
        exp_q.push_back({last_xcare, ev, els, efs, last_col, last_x, last_y,
                         m_busy, ~m_busy, 8'(m_drop)});
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            if (!e[30]) e[23:17] = '0;
            got = {e[30], pix_valid, line_start, frame_start, pix_colour,
                   e[30] ? pix_x : 7'd0, pix_y, busy, plot_ready, drop_count};
            check("pix_stream", got, e);
        end
        if (pix_valid) n_valid++;
        if (line_start) n_ls++;
        if (frame_start) n_fs++;
        if (pix_valid && pix_y == 7'd27 && phase == 2) begin
            if (pix_x == 7'd57) check("px_57_27", pix_colour, 3'b100);
            if (pix_x == 7'd58) check("px_58_27", pix_colour, 3'b111);
            if (pix_x == 7'd59) check("px_59_27", pix_colour, 3'b000);
        end
        if (pix_valid && pix_x == 7'd10 && pix_y == 7'd10) begin
            if (phase == 2) check("px_10_10_old", pix_colour, 3'b100);
            if (phase == 3) check("px_10_10_new", pix_colour, 3'b111);
        end
    endtask

    // Hold reset low two cycles, check reset values, release and reset the model.
    task automatic do_reset();
        reset_n = 1'b0; plot = 1'b0; clear = 1'b0; pix_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", pix_valid, 0);
        check("rst_colour", pix_colour, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_ls", line_start, 0);
        check("rst_fs", frame_start, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ready", plot_ready, 0);
        check("rst_busy", busy, 1);
        reset_n = 1'b1;
        m_busy = 1; m_addr = 0; m_drop = 0; m_h = 0; m_v = 0;
        last_col = '0; last_x = '0; last_y = '0; last_xcare = 1'b1;
        exp_q.delete();
    endtask

    // Step until busy drops (bounded) and check the clear length.
    task automatic run_clear(input string tag, input bit rnd_pen);
        int n = 0;
        while (busy && n < 20000) begin
            step(0, 0, 0, 3'b000, 0, rnd_pen ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check(tag, n, 12288);
    endtask

    task automatic count_reset();
        n_valid = 0; n_ls = 0; n_fs = 0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 3'b000;

        // Reset and automatic clear with a continuous scan.
        phase = 1;
        do_reset();
        run_clear("busy_len", 0);
        check("idle_busy", busy, 0);
        check("idle_ready", plot_ready, 1);

        // One full frame of strobes: tile plots, bad plots, same-address write/read.
        phase = 2;
        count_reset();
        step(1, 57, 27, 3'b100, 0, 1);
        step(1, 58, 27, 3'b111, 0, 1);
        step(1, 10, 10, 3'b100, 0, 1);
        step(1, 127, 96, 3'b110, 0, 1);
        step(1, 0, 100, 3'b110, 0, 1);
        check("drop_two", drop_count, 2);
        for (int i = 5; i < HT * VT; i++) begin
            if (m_h == 10 && m_v == 10) step(1, 10, 10, 3'b111, 0, 1);
            else step(0, 0, 0, 3'b000, 0, 1);
        end
        check("frame_starts", n_fs, 1);
        check("line_starts", n_ls, 96);
        check("valid_slots", n_valid, 12288);

        // Fill the whole store with white.
        phase = 3;
        for (int a = 0; a < DEPTH; a++) step(1, a % W, a / W, 3'b111, 0, 1);
        check("fill_drop", drop_count, 2);

        // Clear from idle, plots while busy, saturation, then reset mid-clear.
        phase = 4;
        step(0, 0, 0, 3'b000, 1, 1'($urandom_range(0, 1)));
        check("clear_busy", busy, 1);
        check("clear_ready", plot_ready, 0);
        step(1, 5, 5, 3'b111, 0, 1'($urandom_range(0, 1)));
        check("busy_drop", drop_count, 3);
        repeat (300) step(1, $urandom_range(0, 127), $urandom_range(0, 127),
                          3'($urandom_range(0, 7)), 0, 1'($urandom_range(0, 1)));
        check("drop_sat", drop_count, 255);
        guard = 0;
        while (m_addr != 5000 && guard < 20000) begin
            step(0, 0, 0, 3'b000, 0, 1'($urandom_range(0, 1)));
            guard++;
        end
        check("reach_5000", guard < 20000, 1);

        phase = 5;
        do_reset();
        run_clear("busy_len_restart", 1);

        // Full frame after the clear: everything reads background.
        phase = 6;
        count_reset();
        for (int i = 0; i < HT * VT; i++) step(0, 0, 0, 3'b000, 0, 1);
        check("frame_starts_2", n_fs, 1);
        check("line_starts_2", n_ls, 96);
        check("valid_slots_2", n_valid, 12288);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stop early once failures pile up.
    initial begin
        wait (failures >= 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #3000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
